// File: rtl/dmem_mmio_responder.sv
// Data-memory port responder: word-addressed RAM below 0x8000_0000 and an MMIO window
// (cycle counter, LEDs, TX byte FIFO, status) above it. Read data is registered.
module dmem_mmio_responder #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned LED_W      = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      address_dmem,
    input  logic [31:0]      data,
    input  logic             wren,
    output logic [31:0]      q_dmem,
    output logic [LED_W-1:0] leds,
    output logic             tx_valid,
    output logic [7:0]       tx_data,
    input  logic             tx_ready,
    output logic             tx_overflow
);

    localparam int unsigned RAM_WORDS = 1 << ADDR_W;
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;

    localparam logic [31:0] ADDR_CYCLE  = 32'h8000_0000;
    localparam logic [31:0] ADDR_LED    = 32'h8000_0001;
    localparam logic [31:0] ADDR_TX     = 32'h8000_0002;
    localparam logic [31:0] ADDR_STATUS = 32'h8000_0003;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [31:0]      ram [RAM_WORDS];
    logic [7:0]       fifo_mem [FIFO_DEPTH];

    logic [31:0]      q_dmem_q;
    logic [31:0]      cycle_q;
    logic [LED_W-1:0] led_q;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             overflow_q, overflow_d;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic              sel_ram;
    logic              sel_cycle;
    logic              sel_led;
    logic              sel_tx;
    logic              sel_status;
    logic [ADDR_W-1:0] ram_idx;

    always_comb begin
        sel_ram    = ~address_dmem[31];
        sel_cycle  = (address_dmem == ADDR_CYCLE);
        sel_led    = (address_dmem == ADDR_LED);
        sel_tx     = (address_dmem == ADDR_TX);
        sel_status = (address_dmem == ADDR_STATUS);
        ram_idx    = address_dmem[ADDR_W-1:0];
    end

    // ------------------------------------------------------------------
    // TX FIFO control
    // ------------------------------------------------------------------
    logic fifo_empty;
    logic fifo_full;
    logic tx_write;
    logic tx_pop;
    logic tx_push;
    logic ovf_set;
    logic ovf_clr;

    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == FULL_CNT);
        tx_write   = wren & sel_tx;
        tx_pop     = ~fifo_empty & tx_ready;
        // A pop on the same edge frees the slot the push needs.
        tx_push    = tx_write & (~fifo_full | tx_pop);
        ovf_set    = tx_write & fifo_full & ~tx_pop;
        ovf_clr    = wren & sel_status & data[10];
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (tx_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (tx_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end

        case ({tx_push, tx_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // Pushing into a slot that becomes the head bypasses the storage write.
        if (tx_push && (wr_ptr_q == rd_ptr_d)) begin
            tx_data_d = data[7:0];
        end else begin
            tx_data_d = fifo_mem[rd_ptr_d];
        end

        overflow_d = ovf_set | (overflow_q & ~ovf_clr);
    end

    // ------------------------------------------------------------------
    // Read mux (pre-edge state of every source)
    // ------------------------------------------------------------------
    logic [31:0] status_word;
    logic [31:0] rd_data;

    always_comb begin
        status_word = {21'b0, overflow_q, fifo_empty, fifo_full, 8'(count_q)};

        rd_data = '0;
        if (sel_ram) begin
            rd_data = ram[ram_idx];
        end else if (sel_cycle) begin
            rd_data = cycle_q;
        end else if (sel_led) begin
            rd_data = 32'(led_q);
        end else if (sel_status) begin
            rd_data = status_word;
        end
    end

    // ------------------------------------------------------------------
    // Unreset storage: RAM and FIFO entries
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset && wren && sel_ram) begin
            ram[ram_idx] <= data;
        end
        if (!reset && tx_push) begin
            fifo_mem[wr_ptr_q] <= data[7:0];
        end
    end

    // ------------------------------------------------------------------
    // Reset state
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            q_dmem_q   <= '0;
            cycle_q    <= '0;
            led_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            tx_data_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            q_dmem_q   <= rd_data;
            cycle_q    <= cycle_q + 32'd1;
            if (wren && sel_led) begin
                led_q <= data[LED_W-1:0];
            end
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            tx_data_q  <= tx_data_d;
            overflow_q <= overflow_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        q_dmem      = q_dmem_q;
        leds        = led_q;
        tx_valid    = ~fifo_empty;
        tx_data     = tx_data_q;
        tx_overflow = overflow_q;
    end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder: RAM, MMIO registers, TX FIFO and reset behaviour.
module tb_dmem_mmio_responder;

    localparam logic [31:0] A_CYCLE  = 32'h8000_0000;
    localparam logic [31:0] A_LED    = 32'h8000_0001;
    localparam logic [31:0] A_TX     = 32'h8000_0002;
    localparam logic [31:0] A_STATUS = 32'h8000_0003;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;
    logic [15:0] leds;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        tx_overflow;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    dmem_mmio_responder #(
        .ADDR_W    (12),
        .LED_W     (16),
        .FIFO_DEPTH(4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .address_dmem(address_dmem),
        .data        (data),
        .wren        (wren),
        .q_dmem      (q_dmem),
        .leds        (leds),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .tx_overflow (tx_overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic we);
        address_dmem = a;
        data         = d;
        wren         = we;
    endtask

    initial begin
        reset    = 1'b1;
        tx_ready = 1'b0;
        drive(32'h0, 32'h0, 1'b0);
        tick();
        tick();
        check("rst_q", q_dmem, 32'h0);
        check("rst_leds", {16'h0, leds}, 32'h0);
        check("rst_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_txdata", {24'h0, tx_data}, 32'h0);
        check("rst_ovf", {31'h0, tx_overflow}, 32'h0);

        // Counter: fifth non-reset edge reads the value 4.
        reset = 1'b0;
        drive(A_CYCLE, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        check("cycle_4", q_dmem, 32'h4);
        drive(A_STATUS, 32'h0, 1'b0);
        tick();
        check("status_idle", q_dmem, 32'h0000_0200);

        // RAM write/read, alias, read-first
        drive(32'h005, 32'hDEAD_BEEF, 1'b1);
        tick();
        drive(32'h005, 32'h0, 1'b0);
        tick();
        check("ram_rd", q_dmem, 32'hDEAD_BEEF);
        drive(32'h1005, 32'h0, 1'b0);
        tick();
        check("ram_alias", q_dmem, 32'hDEAD_BEEF);
        drive(32'h005, 32'h1, 1'b1);
        tick();
        check("ram_rd_first", q_dmem, 32'hDEAD_BEEF);
        drive(32'h005, 32'h0, 1'b0);
        tick();
        check("ram_new", q_dmem, 32'h1);

        // Overfill the FIFO with the sink stalled
        for (int i = 0; i < 5; i++) begin
            drive(A_TX, 32'h41 + i, 1'b1);
            tick();
        end
        drive(A_STATUS, 32'h0, 1'b0);
        tick();
        check("status_ovf", q_dmem, 32'h0000_0504);
        check("ovf_flag", {31'h0, tx_overflow}, 32'h1);
        check("head_stall", {24'h0, tx_data}, 32'h41);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", {31'h0, tx_valid}, 32'h1);
            check("drain_byte", {24'h0, tx_data}, 32'h41 + i);
            tick();
        end
        check("drain_empty", {31'h0, tx_valid}, 32'h0);
        tx_ready = 1'b0;

        // Clear overflow, refill, then push and pop on the same edge while full
        drive(A_STATUS, 32'h400, 1'b1);
        tick();
        check("ovf_clr", {31'h0, tx_overflow}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            drive(A_TX, 32'h61 + i, 1'b1);
            tick();
        end
        drive(A_TX, 32'h55, 1'b1);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        drive(A_STATUS, 32'h0, 1'b0);
        tick();
        check("status_full_pp", q_dmem, 32'h0000_0104);
        check("ovf_pp", {31'h0, tx_overflow}, 32'h0);
        tx_ready = 1'b1;
        check("pp_b0", {24'h0, tx_data}, 32'h62);
        tick();
        check("pp_b1", {24'h0, tx_data}, 32'h63);
        tick();
        check("pp_b2", {24'h0, tx_data}, 32'h64);
        tick();
        check("pp_b3", {24'h0, tx_data}, 32'h55);
        check("pp_v3", {31'h0, tx_valid}, 32'h1);
        tick();
        check("pp_empty", {31'h0, tx_valid}, 32'h0);
        tx_ready = 1'b0;

        // LED register
        drive(A_LED, 32'h0000_ABCD, 1'b1);
        tick();
        check("leds_wr", {16'h0, leds}, 32'h0000_ABCD);
        drive(A_LED, 32'h0, 1'b0);
        tick();
        check("led_rd", q_dmem, 32'h0000_ABCD);

        // Overflow again, then clear via STATUS (read sees pre-edge state)
        for (int i = 0; i < 5; i++) begin
            drive(A_TX, 32'h71 + i, 1'b1);
            tick();
        end
        check("ovf_again", {31'h0, tx_overflow}, 32'h1);
        drive(A_STATUS, 32'h400, 1'b1);
        tick();
        check("status_pre_clr", q_dmem, 32'h0000_0504);
        check("ovf_clr2", {31'h0, tx_overflow}, 32'h0);
        drive(32'h8000_0007, 32'hFFFF_FFFF, 1'b1);
        tick();
        check("unmapped_rd", q_dmem, 32'h0);
        check("unmapped_wr", {16'h0, leds}, 32'h0000_ABCD);

        // Leave two bytes queued
        drive(A_STATUS, 32'h0, 1'b0);
        tx_ready = 1'b1;
        tick();
        tick();
        tx_ready = 1'b0;
        tick();
        check("status_two", q_dmem, 32'h0000_0002);
        check("head_two", {24'h0, tx_data}, 32'h73);

        // Counter wrap
        force dut.cycle_q = 32'hFFFF_FFFE;
        drive(A_CYCLE, 32'h0, 1'b0);
        #1;
        release dut.cycle_q;
        tick();
        check("wrap_0", q_dmem, 32'hFFFF_FFFE);
        tick();
        check("wrap_1", q_dmem, 32'hFFFF_FFFF);
        tick();
        check("wrap_2", q_dmem, 32'h0);

        // Reset with bytes queued and a write/handshake at the reset edge
        reset    = 1'b1;
        tx_ready = 1'b1;
        drive(A_LED, 32'h1234, 1'b1);
        tick();
        check("mid_rst_valid", {31'h0, tx_valid}, 32'h0);
        check("mid_rst_leds", {16'h0, leds}, 32'h0);
        check("mid_rst_q", q_dmem, 32'h0);
        check("mid_rst_txdata", {24'h0, tx_data}, 32'h0);
        reset    = 1'b0;
        tx_ready = 1'b0;
        drive(A_STATUS, 32'h0, 1'b0);
        tick();
        check("post_rst_status", q_dmem, 32'h0000_0200);
        check("post_rst_leds", {16'h0, leds}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
- Responder on the processor's data-memory port (address_dmem/data/wren -> q_dmem).
- Decodes each access to either a word-addressed data RAM or a small memory-mapped I/O window.
- I/O window holds a free-running cycle counter, an LED register, a transmit FIFO and a status register.
- The TX FIFO drains to an external byte sink over a valid/ready handshake.

Parameters:
ADDR_W, 12, RAM index width; RAM holds 2^ADDR_W 32-bit words
LED_W, 16, LED register width
FIFO_DEPTH, 4, TX FIFO entries (power of two, >=2)

Ports:
clock  input  1  master clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
address_dmem  input  32  word address from processor
data  input  32  write data from processor
wren  input  1  write enable from processor
q_dmem  output  32  registered read data
leds  output  LED_W  LED register contents
tx_valid  output  1  FIFO head valid
tx_data  output  8  FIFO head byte
tx_ready  input  1  sink accepts head this cycle
tx_overflow  output  1  sticky: a push was dropped while the FIFO was full

Behaviour:
- Clocking/reset: one clock, named clock; reset is synchronous and active-high, named reset.
- Values after a reset edge:
  - q_dmem=0, leds=0, tx_valid=0, tx_data=0, tx_overflow=0.
  - Cycle counter=0; FIFO empty (pointers and count 0).
- RAM contents are not reset.
- Reset mid-operation:
  - Queued FIFO bytes are discarded.
  - A wren asserted at the reset edge is ignored (RAM, LED and FIFO unchanged).
  - A tx_ready handshake at the reset edge is ignored.
- Address decode:
  - address_dmem[31]=0: RAM, index=address_dmem[ADDR_W-1:0]. Bits [30:ADDR_W] are ignored, so RAM aliases.
  - 0x8000_0000 CYCLE (RO): writes ignored.
  - 0x8000_0001 LED (RW): write stores data[LED_W-1:0]; read returns zero-extended leds.
  - 0x8000_0002 TX (WO): write pushes data[7:0]; read returns 0.
  - 0x8000_0003 STATUS: read = {21'b0, overflow[10], empty[9], full[8], count[7:0]}. Write with data[10]=1 clears overflow; other written bits are ignored.
  - Any other address with bit31=1: read 0, writes ignored.
- Read timing: address_dmem is sampled at rising edge N. q_dmem holds the result from edge N until edge N+1 (one-cycle registered latency). Reads happen every cycle regardless of wren.
- Read-during-write to the same RAM word is read-first: q_dmem shows the old word and the new value is visible on the next access.
- MMIO reads return the pre-edge state. CYCLE reads its value before that edge's increment; STATUS ignores a same-edge push or pop.
- Cycle counter: 32-bit, +1 every non-reset cycle, wraps 0xFFFF_FFFF -> 0.
- TX FIFO:
  - tx_valid = (count!=0); tx_data = head byte, registered from the FIFO storage, stable while tx_valid=1 and tx_ready=0.
  - Pop occurs when tx_valid & tx_ready at an edge.
  - Push occurs on a write to TX. If full and no same-edge pop, the byte is dropped and overflow is set.
  - Full with simultaneous pop and push: both take effect, count stays FIFO_DEPTH, no overflow.
  - Empty with push: no pop is possible; tx_valid rises the cycle after the push edge.
  - Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
  - Overflow set and clear on the same edge: set wins.
- tx_overflow mirrors STATUS[10].

Test Plan:
- Reset then idle 5 cycles, read 0x8000_0000 -> q_dmem=4. Read 0x8000_0003 -> 0x0000_0200 (empty, count 0).
- Write 0xDEAD_BEEF to RAM 0x005, then read 0x005 -> 0xDEAD_BEEF. Read 0x1005 (alias) -> 0xDEAD_BEEF. Write 0x1 to 0x005 while reading 0x005 on the same edge -> q_dmem=0xDEAD_BEEF, next read 0x1.
- tx_ready=0, write 0x41,0x42,0x43,0x44,0x45 to TX:
  - STATUS -> 0x0000_0504 (overflow, full, count 4); tx_overflow=1.
  - Raise tx_ready: bytes 0x41..0x44 appear in order over 4 cycles, then tx_valid=0.
- With the FIFO full and tx_ready=1, push 0x55 on the same edge as a pop -> count remains 4, overflow unchanged (0 after a prior clear), 0x55 delivered last.
- Write 0x0000_ABCD to LED -> leds=0xABCD, read LED -> 0x0000_ABCD. Write 0x400 to STATUS -> tx_overflow=0. Read 0x8000_0007 -> 0.
- Counter wrap: force counter to 0xFFFF_FFFE, then read CYCLE on three successive cycles -> 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000. Assert reset with 2 bytes queued -> tx_valid=0 and leds=0 the next cycle.
